// File: rtl/trace_dct_packer.sv
// trace_dct_packer
//   Upstream stage of the CPU OCI trace monitor. Packs SYM_W-bit compressed
//   trace symbols into a DATA_W-bit buffer, newest symbol at the bottom. Each
//   full or flushed word goes to a single output register slot. The block also
//   sequences end-of-test.
//
// Handshakes (strict valid/ready, both sides):
//   A transfer happens on a rising edge where valid & ready are both high.
//   valid never depends on ready. A holder of valid keeps its payload stable
//   until the transfer happens.
//     symbol side : sym_valid/sym_ready, payload sym
//     word side   : word_valid/word_ready, payload word_data/word_count
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   sym_valid/sym/sym_ready   incoming trace symbols
//   flush               1-cycle pulse: emit the partial word (if any)
//   end_req             1-cycle pulse: drain and end the test
//   dct_buffer/dct_count      live packing buffer and its symbol count
//   word_valid/word_data/word_count/word_ready   output slot
//   overflow            sticky: a symbol was offered while not ready
//   test_ending         end-of-test drain in progress
//   test_has_ended      drain finished; stays high until reset
//   dbg_state           current FSM state (0 RUN, 1 FLUSH_WAIT,
//                       2 END_DRAIN, 3 ENDED)
module trace_dct_packer #(
  parameter int DATA_W = 30,
  parameter int SYM_W  = 2,
  parameter int SYMS   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sym_valid,
  input  logic [SYM_W-1:0]  sym,
  output logic              sym_ready,
  input  logic              flush,
  input  logic              end_req,
  output logic [DATA_W-1:0] dct_buffer,
  output logic [3:0]        dct_count,
  output logic              word_valid,
  output logic [DATA_W-1:0] word_data,
  output logic [3:0]        word_count,
  input  logic              word_ready,
  output logic              overflow,
  output logic              test_ending,
  output logic              test_has_ended,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH_WAIT = 2'd1,
    END_DRAIN  = 2'd2,
    ENDED      = 2'd3
  } state_t;

  localparam logic [3:0] FULL_CNT = 4'(SYMS);

  state_t             r_state;
  logic [DATA_W-1:0]  r_buf;
  logic [3:0]         r_cnt;
  logic               r_word_valid;
  logic [DATA_W-1:0]  r_word_data;
  logic [3:0]         r_word_count;
  logic               r_overflow;
  logic               r_end_pend;

  state_t             w_state_nxt;
  logic               w_end_pend_nxt;
  logic               w_push;
  logic               w_accept;
  logic               w_slot_free;
  logic               w_pop;
  logic [DATA_W-1:0]  w_buf_acc;
  logic [3:0]         w_cnt_acc;

  assign sym_ready   = (r_state == RUN) && (r_cnt != FULL_CNT);
  assign w_accept    = sym_valid & sym_ready;
  assign w_slot_free = !r_word_valid || word_ready;
  assign w_pop       = r_word_valid && word_ready;

  // Buffer and count as they look with this cycle's symbol included. Any
  // transfer decided this cycle takes these values, so a symbol accepted
  // together with flush or end_req lands in the emitted word.
  assign w_buf_acc = w_accept ? {r_buf[DATA_W-SYM_W-1:0], sym} : r_buf;
  assign w_cnt_acc = r_cnt + {3'b000, w_accept};

  always_comb begin
    w_state_nxt    = r_state;
    w_end_pend_nxt = r_end_pend;
    w_push         = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_cnt_acc == FULL_CNT && w_slot_free) w_push = 1'b1;
        if (end_req) begin
          w_state_nxt = END_DRAIN;
          if (w_cnt_acc != 4'd0 && w_slot_free) w_push = 1'b1;
        end else if (flush && w_cnt_acc != 4'd0) begin
          if (w_slot_free) w_push = 1'b1;
          else             w_state_nxt = FLUSH_WAIT;
        end
      end
      FLUSH_WAIT: begin
        if (end_req) w_end_pend_nxt = 1'b1;
        if (w_slot_free) begin
          w_push         = 1'b1;
          // A pending end request starts the drain immediately. The count is
          // zero after this push, so END_DRAIN only waits for the slot.
          w_state_nxt    = (r_end_pend || end_req) ? END_DRAIN : RUN;
          w_end_pend_nxt = 1'b0;
        end
      end
      END_DRAIN: begin
        if (r_cnt != 4'd0) begin
          if (w_slot_free) w_push = 1'b1;
        end else if (w_slot_free) begin
          w_state_nxt = ENDED;
        end
      end
      ENDED: begin
        w_state_nxt = ENDED;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_buf        <= '0;
      r_cnt        <= '0;
      r_word_valid <= 1'b0;
      r_word_data  <= '0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_end_pend   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_end_pend <= w_end_pend_nxt;
      if (sym_valid && !sym_ready) r_overflow <= 1'b1;
      if (w_push) begin
        r_word_valid <= 1'b1;
        r_word_data  <= w_buf_acc;
        r_word_count <= w_cnt_acc;
        r_buf        <= '0;
        r_cnt        <= '0;
      end else begin
        if (w_pop) r_word_valid <= 1'b0;
        r_buf <= w_buf_acc;
        r_cnt <= w_cnt_acc;
      end
    end
  end

  assign dct_buffer     = r_buf;
  assign dct_count      = r_cnt;
  assign word_valid     = r_word_valid;
  assign word_data      = r_word_data;
  assign word_count     = r_word_count;
  assign overflow       = r_overflow;
  assign test_ending    = (r_state == END_DRAIN);
  assign test_has_ended = (r_state == ENDED);
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_trace_dct_packer.sv
module tb_trace_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sym_valid;
  logic [1:0]  sym;
  logic        sym_ready;
  logic        flush;
  logic        end_req;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        word_valid;
  logic [29:0] word_data;
  logic [3:0]  word_count;
  logic        word_ready;
  logic        overflow;
  logic        test_ending;
  logic        test_has_ended;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  trace_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .sym_valid      (sym_valid),
    .sym            (sym),
    .sym_ready      (sym_ready),
    .flush          (flush),
    .end_req        (end_req),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .word_valid     (word_valid),
    .word_data      (word_data),
    .word_count     (word_count),
    .word_ready     (word_ready),
    .overflow       (overflow),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // One rising edge, then settle: inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_n(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      sym_valid = 1'b1;
      sym       = s;
      tick();
    end
    sym_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; sym_valid = 1'b0; sym = 2'b00;
    flush = 1'b0; end_req = 1'b0; word_ready = 1'b1;
    tick();
    do_reset();

    // reset state
    check("rst_cnt",   dct_count, 0);
    check("rst_buf",   dct_buffer, 0);
    check("rst_wv",    word_valid, 0);
    check("rst_ovf",   overflow, 0);
    check("rst_end",   test_has_ended, 0);
    check("rst_rdy",   sym_ready, 1);

    // 15 x 01 with the slot free: word one cycle after the 15th accept
    for (int i = 0; i < 15; i++) begin
      sym_valid = 1'b1; sym = 2'b01;
      check("t1_rdy", sym_ready, 1);
      tick();
    end
    sym_valid = 1'b0;
    check("t1_wv",    word_valid, 1);
    check("t1_data",  word_data, 32'h15555555);
    check("t1_wcnt",  word_count, 15);
    check("t1_cnt",   dct_count, 0);
    tick();
    check("t1_pop",   word_valid, 0);

    // 3,2,1 then flush
    send_n(2'd3, 1); send_n(2'd2, 1); send_n(2'd1, 1);
    check("t2_pre_cnt", dct_count, 3);
    flush = 1'b1; tick(); flush = 1'b0;
    check("t2_wv",   word_valid, 1);
    check("t2_data", word_data, 32'h00000039);
    check("t2_wcnt", word_count, 3);
    check("t2_buf",  dct_buffer, 0);
    check("t2_cnt",  dct_count, 0);
    tick();

    // back-pressure: 31 x 10 with word_ready low
    word_ready = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      sym_valid = 1'b1; sym = 2'b10;
      tick();
      if (i == 15) begin
        check("t3_w1_wv",  word_valid, 1);
        check("t3_w1_cnt", dct_count, 0);
      end
      if (i == 30) check("t3_ovf_pre", overflow, 0);
    end
    sym_valid = 1'b0;
    check("t3_cnt",   dct_count, 15);
    check("t3_rdy",   sym_ready, 0);
    check("t3_ovf",   overflow, 1);
    check("t3_hold",  word_data, 32'h2AAAAAAA);
    word_ready = 1'b1;
    tick();
    check("t3_w2_wv",   word_valid, 1);
    check("t3_w2_data", word_data, 32'h2AAAAAAA);
    check("t3_w2_wcnt", word_count, 15);
    check("t3_w2_cnt",  dct_count, 0);
    tick();
    check("t3_w2_pop",  word_valid, 0);
    check("t3_ovf_keep", overflow, 1);

    // end-of-test drain with the slot stalled
    do_reset();
    check("t4_ovf_clr", overflow, 0);
    send_n(2'd3, 5);
    word_ready = 1'b0;
    end_req = 1'b1; tick(); end_req = 1'b0;
    check("t4_ending", test_ending, 1);
    check("t4_rdy",    sym_ready, 0);
    repeat (4) tick();
    check("t4_not_ended", test_has_ended, 0);
    check("t4_data",   word_data, 32'h000003FF);
    check("t4_wcnt",   word_count, 5);
    word_ready = 1'b1;
    tick();
    check("t4_pop",    word_valid, 0);
    check("t4_ended",  test_has_ended, 1);
    check("t4_ending_lo", test_ending, 0);
    flush = 1'b1; end_req = 1'b1; tick(); flush = 1'b0; end_req = 1'b0;
    check("t4_stay",   test_has_ended, 1);
    check("t4_no_word", word_valid, 0);

    // reset mid-stream
    do_reset();
    send_n(2'd1, 7);
    check("t5_pre_cnt", dct_count, 7);
    do_reset();
    check("t5_buf",   dct_buffer, 0);
    check("t5_cnt",   dct_count, 0);
    check("t5_wv",    word_valid, 0);
    check("t5_ovf",   overflow, 0);
    check("t5_end",   test_has_ended, 0);
    send_n(2'd1, 15);
    check("t5_wv2",   word_valid, 1);
    check("t5_data",  word_data, 32'h15555555);
    check("t5_wcnt",  word_count, 15);
    tick();

    // flush on the 14th accept, then flush at count 0
    send_n(2'd3, 13);
    sym_valid = 1'b1; sym = 2'd3; flush = 1'b1;
    tick();
    sym_valid = 1'b0; flush = 1'b0;
    check("t6_wv",    word_valid, 1);
    check("t6_wcnt",  word_count, 14);
    check("t6_data",  word_data, 32'h0FFFFFFF);
    check("t6_cnt",   dct_count, 0);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    check("t6_empty_flush", word_valid, 0);
    tick();
    check("t6_empty_flush2", word_valid, 0);
    check("t6_state", dbg_state, 0);

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_dct_packer.md
Name: trace_dct_packer

Overview:
- Upstream stage of the CPU OCI trace test-bench monitor.
- Packs 2-bit compressed debug-trace symbols into a 30-bit dct_buffer with a 4-bit dct_count.
- Hands completed or flushed words downstream through a valid/ready register slot.
- Sequences end-of-test: drives test_ending while draining, then test_has_ended once the final word has been taken.

Parameters:
- DATA_W, 30, packed word width; must equal SYM_W*SYMS.
- SYM_W, 2, trace symbol width.
- SYMS, 15, symbols per word; must be ≤15 so it fits the 4-bit count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sym_valid  in  1  trace symbol offered.
- sym  in  2  trace symbol.
- sym_ready  out  1  packer can accept a symbol this cycle.
- flush  in  1  single-cycle request to emit a partial word.
- end_req  in  1  single-cycle request to end the test.
- dct_buffer  out  30  live packing buffer; newest symbol in bits [1:0].
- dct_count  out  4  symbols currently held in dct_buffer.
- word_valid  out  1  output slot holds a word.
- word_data  out  30  packed word.
- word_count  out  4  valid symbols in word_data (1..15).
- word_ready  in  1  consumer takes the word when word_valid&word_ready.
- overflow  out  1  sticky: a symbol was offered while sym_ready=0.
- test_ending  out  1  high while the end-of-test drain is in progress.
- test_has_ended  out  1  high after the final drain completes.

Behaviour:
- Reset (synchronous, active-high) clears all outputs and registers to 0 and sets state RUN. This applies mid-operation: the slot word is discarded and no partial word is emitted.
- Accept condition: sym_valid & sym_ready. On accept:
  - dct_buffer <= {dct_buffer[27:0], sym}
  - dct_count <= dct_count+1
- Slot free condition: !word_valid | word_ready. A pop and a push into the slot may happen in the same cycle.
- Full transfer:
  - Trigger: dct_count reaches 15 (either after an accept, or already 15) and the slot is free.
  - Action: next cycle word_data = buffer, word_count = 15, word_valid = 1, dct_buffer = 0, dct_count = 0.
  - Latency: word_valid rises 1 cycle after the 15th accept when the slot is free.
  - If the slot is busy, the buffer holds at count 15 until the slot frees.
- sym_ready = (state==RUN) & (dct_count!=15).
- Overflow: sym_valid & !sym_ready sets overflow. The symbol is dropped. overflow clears only on reset.
- State RUN:
  - flush with post-accept count>0 → move the partial word (count 1..14) to the slot if free, else go to FLUSH_WAIT.
  - flush with count 0 → no word emitted.
  - A symbol accepted in the same cycle as flush is included in the flushed word.
  - end_req → go to END_DRAIN, with the same inclusion rule for a same-cycle symbol.
  - end_req takes priority over flush.
- State FLUSH_WAIT:
  - sym_ready = 0.
  - Transfer the partial word when the slot frees, then return to RUN.
  - end_req in this state is latched and actioned on return.
- State END_DRAIN:
  - test_ending = 1, sym_ready = 0.
  - Transfer any remaining partial word when the slot frees.
  - When dct_count==0 and the slot is empty (or popping this cycle), go to ENDED next cycle.
- State ENDED:
  - test_ending = 0, test_has_ended = 1, sym_ready = 0.
  - Stays in ENDED until reset.
  - flush and end_req are ignored.
- word_data and word_count are held stable while word_valid & !word_ready.
- Partial words are not padded: unused high bits are 0.

Test Plan:
- Reset, word_ready=1, sym=2'b01 accepted on 15 consecutive cycles → next cycle word_valid=1, word_data=30'h15555555, word_count=15, dct_count=0; sym_ready stays 1 throughout.
- Accept 3,2,1 then pulse flush → word_data=30'h00000039, word_count=3; dct_buffer=0 and dct_count=0 the same cycle.
- word_ready=0, offer 31 symbols of 2'b10 → first word held, dct_count=15, sym_ready=0, 31st symbol dropped with overflow=1. Then word_ready=1 → two words 30'h2AAAAAAA delivered on consecutive cycles; overflow stays 1.
- Accept 5 symbols of 2'b11, pulse end_req with word_ready=0 → test_ending=1, sym_ready=0. After 4 cycles set word_ready=1 → word_data=30'h3FF, word_count=5 popped; next cycle test_has_ended=1, test_ending=0.
- Accept 7 symbols, assert reset for one cycle mid-stream → dct_buffer=0, dct_count=0, word_valid=0, overflow=0, test_has_ended=0; the next 15 symbols pack normally.
- Accept 14 symbols with flush asserted on the cycle of the 14th → word_count=14. Then flush with count 0 → no word_valid pulse.
